// File: rtl/dense_layer_seq.sv
// Time-multiplexed dense layer: one signed MAC per cycle against an external
// weight/bias memory, then requantise, optional ReLU, saturate and running argmax.
module dense_layer_seq #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 8,
  parameter int IN_W     = 16,
  parameter int W_W      = 16,
  parameter int OUT_W    = 16,
  parameter int FRAC     = 8,
  parameter int RELU     = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [IN_SIZE-1:0][IN_W-1:0]            input_vector,
  output logic                                    weight_rd,
  output logic [$clog2(OUT_SIZE*(IN_SIZE+1))-1:0] weight_addr,
  input  logic [W_W-1:0]                          weight_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUT_SIZE-1:0][OUT_W-1:0]          output_vector,
  output logic [$clog2(OUT_SIZE)-1:0]             output_index
);
  localparam int ADDR_W = $clog2(OUT_SIZE*(IN_SIZE+1));
  localparam int IDX_W  = $clog2(OUT_SIZE);
  localparam int I_W    = $clog2(IN_SIZE+1);
  localparam int SEL_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int P_W    = IN_W + W_W;
  localparam int ACC_W  = P_W + I_W + FRAC + 1;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t                       state;
  logic [IN_SIZE-1:0][IN_W-1:0] in_q;
  logic [IDX_W-1:0]             n;
  logic [I_W-1:0]               i;
  logic [ADDR_W-1:0]            addr;
  logic signed [ACC_W-1:0]      acc;
  logic signed [OUT_W-1:0]      max_val;

  logic [I_W-1:0]          i_m1;
  logic signed [IN_W-1:0]  cur_in;
  logic signed [W_W-1:0]   w_s;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, sum, q;
  logic signed [OUT_W-1:0] res;

  // Read data lags the address by one cycle, so cycle i pairs with input i-1.
  assign i_m1     = i - I_W'(1);
  assign cur_in   = in_q[i_m1[SEL_W-1:0]];
  assign w_s      = weight_data;
  assign prod     = cur_in * w_s;
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-W_W-FRAC){weight_data[W_W-1]}}, weight_data, {FRAC{1'b0}}};

  always_comb begin
    sum = acc + bias_ext;
    q   = sum >>> FRAC;
    if (RELU != 0 && q[ACC_W-1]) q = '0;
    if (q > MAXV)      res = MAXV[OUT_W-1:0];
    else if (q < MINV) res = MINV[OUT_W-1:0];
    else               res = q[OUT_W-1:0];
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign weight_rd   = (state == RUN);
  assign weight_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_q          <= '0;
      n             <= '0;
      i             <= '0;
      addr          <= '0;
      acc           <= '0;
      max_val       <= '0;
      output_vector <= '0;
      output_index  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_q         <= input_vector;
          n            <= '0;
          i            <= '0;
          addr         <= '0;
          acc          <= '0;
          max_val      <= '0;
          output_index <= '0;
          state        <= RUN;
        end
        // Addresses are contiguous across neurons, so addr just counts RUN cycles.
        RUN: begin
          addr <= addr + ADDR_W'(1);
          i    <= i + I_W'(1);
          if (i != '0) acc <= acc + prod_ext;
          if (i == I_W'(IN_SIZE)) state <= FINISH;
        end
        FINISH: begin
          output_vector[n] <= res;
          if (n == '0 || res > max_val) begin
            max_val      <= res;
            output_index <= n;
          end
          acc <= '0;
          i   <= '0;
          if (n == IDX_W'(OUT_SIZE-1)) state <= DONE;
          else begin
            n     <= n + IDX_W'(1);
            state <= RUN;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: 4 inputs x 3 neurons, one ReLU and one
// linear instance, each backed by a 1-cycle-latency weight memory.
module tb_dense_layer_seq;
  localparam int IN_SIZE = 4, OUT_SIZE = 3, NW = OUT_SIZE*(IN_SIZE+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv0, ir0, rd0, ovl0, ordy0;
  logic [3:0][15:0] vin0;
  logic [3:0] addr0;
  logic [15:0] wd0;
  logic [2:0][15:0] ov0;
  logic [1:0] idx0;

  logic iv1, ir1, rd1, ovl1, ordy1;
  logic [3:0][15:0] vin1;
  logic [3:0] addr1;
  logic [15:0] wd1;
  logic [2:0][15:0] ov1;
  logic [1:0] idx1;

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];

  int total = 0, passed = 0;

  dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(3), .IN_W(16), .W_W(16), .OUT_W(16), .FRAC(8), .RELU(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .input_vector(vin0),
    .weight_rd(rd0), .weight_addr(addr0), .weight_data(wd0),
    .out_valid(ovl0), .out_ready(ordy0), .output_vector(ov0), .output_index(idx0));

  dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(3), .IN_W(16), .W_W(16), .OUT_W(16), .FRAC(8), .RELU(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .input_vector(vin1),
    .weight_rd(rd1), .weight_addr(addr1), .weight_data(wd1),
    .out_valid(ovl1), .out_ready(ordy1), .output_vector(ov1), .output_index(idx1));

  always @(posedge clk) if (rd0) wd0 <= mem0[addr0];
  always @(posedge clk) if (rd1) wd1 <= mem1[addr1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input bit which, input int w0, b0, w1, b1, w2, b2);
    int w [3];
    int b [3];
    w = '{w0, w1, w2};
    b = '{b0, b1, b2};
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i <= IN_SIZE; i++) begin
        if (which) mem1[n*5+i] = 16'((i == IN_SIZE) ? b[n] : w[n]);
        else       mem0[n*5+i] = 16'((i == IN_SIZE) ? b[n] : w[n]);
      end
    end
  endtask

  task automatic run0(input logic [3:0][15:0] v, output int lat);
    iv0 = 1'b1; vin0 = v;
    tick;
    iv0 = 1'b0; lat = 1;
    while (!ovl0 && lat < 200) begin tick; lat++; end
  endtask

  task automatic run1(input logic [3:0][15:0] v, output int lat);
    iv1 = 1'b1; vin1 = v;
    tick;
    iv1 = 1'b0; lat = 1;
    while (!ovl1 && lat < 200) begin tick; lat++; end
  endtask

  task automatic consume0;
    ordy0 = 1'b1; tick; ordy0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; ordy0 = 1'b0; ordy1 = 1'b0;
    vin0 = '0; vin1 = '0;
    repeat (2) tick;
    total++;
    if (ir0 !== 1'b1 || ovl0 !== 1'b0 || rd0 !== 1'b0 || addr0 !== 4'd0)
      $display("FAIL reset ctrl: in_ready=%b out_valid=%b rd=%b addr=%0d want 1 0 0 0", ir0, ovl0, rd0, addr0);
    else passed++;
    total++;
    if (ov0 !== '0 || idx0 !== 2'd0 || ov1 !== '0)
      $display("FAIL reset data: ov0=%h idx0=%0d ov1=%h want 0", ov0, idx0, ov1);
    else passed++;
    rst = 1'b0;
    tick;
    total++;
    if (ir0 !== 1'b1 || rd0 !== 1'b0)
      $display("FAIL reset idle: in_ready=%b rd=%b want 1 0", ir0, rd0);
    else passed++;
  endtask

  task automatic test_basic;
    int lat;
    int e [3];
    e = '{1024, 0, 768};
    set_mem(0, 256, 0, -256, 0, 128, 256);
    run0({4{16'd256}}, lat);
    total++;
    if (lat !== 19) $display("FAIL basic latency: got %0d want 19", lat); else passed++;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov0[j] !== 16'(e[j])) $display("FAIL basic out[%0d]: got %0d want %0d", j, $signed(ov0[j]), e[j]);
      else passed++;
    end
    total++;
    if (idx0 !== 2'd0 || ir0 !== 1'b0 || rd0 !== 1'b0)
      $display("FAIL basic done: idx=%0d in_ready=%b rd=%b want 0 0 0", idx0, ir0, rd0);
    else passed++;
    consume0;
    total++;
    if (ovl0 !== 1'b0 || ir0 !== 1'b1)
      $display("FAIL basic consume: out_valid=%b in_ready=%b want 0 1", ovl0, ir0);
    else passed++;
  endtask

  task automatic test_argmax_tie;
    int lat;
    int e [3];
    e = '{100, 500, 500};
    set_mem(0, 25, 0, 125, 0, 0, 500);
    run0({4{16'd256}}, lat);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov0[j] !== 16'(e[j])) $display("FAIL tie out[%0d]: got %0d want %0d", j, $signed(ov0[j]), e[j]);
      else passed++;
    end
    total++;
    if (idx0 !== 2'd1) $display("FAIL tie index: got %0d want 1", idx0); else passed++;
    consume0;
  endtask

  task automatic test_saturation;
    int lat;
    set_mem(0, 32767, 32767, 32767, 32767, 32767, 32767);
    run0({4{16'd32767}}, lat);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov0[j] !== 16'h7FFF) $display("FAIL sat_pos out[%0d]: got %0d want 32767", j, $signed(ov0[j]));
      else passed++;
    end
    total++;
    if (idx0 !== 2'd0) $display("FAIL sat_pos index: got %0d want 0", idx0); else passed++;
    consume0;
    set_mem(1, -32768, -32768, -32768, -32768, -32768, -32768);
    run1({4{16'd32767}}, lat);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov1[j] !== 16'h8000) $display("FAIL sat_neg out[%0d]: got %0d want -32768", j, $signed(ov1[j]));
      else passed++;
    end
    ordy1 = 1'b1; tick; ordy1 = 1'b0;
  endtask

  task automatic test_floor;
    int lat;
    int e [3];
    e = '{-1, 0, -3};
    set_mem(1, -1, 0, 1, 0, 0, -3);
    run1({4{16'd1}}, lat);
    total++;
    if (lat !== 19) $display("FAIL floor latency: got %0d want 19", lat); else passed++;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov1[j] !== 16'(e[j])) $display("FAIL floor out[%0d]: got %0d want %0d", j, $signed(ov1[j]), e[j]);
      else passed++;
    end
    total++;
    if (idx1 !== 2'd1) $display("FAIL floor index: got %0d want 1", idx1); else passed++;
    ordy1 = 1'b1; tick; ordy1 = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    set_mem(0, 256, 0, -256, 0, 128, 256);
    run0({4{16'd256}}, lat);
    for (int k = 0; k < 10; k++) begin
      iv0 = (k % 2 == 0);
      vin0 = {4{16'(k * 97 + 3)}};
      tick;
      total++;
      if (ovl0 !== 1'b1 || ir0 !== 1'b0 || rd0 !== 1'b0 || idx0 !== 2'd0 ||
          ov0[0] !== 16'd1024 || ov0[1] !== 16'd0 || ov0[2] !== 16'd768)
        $display("FAIL hold cyc%0d: ov=%b ir=%b rd=%b idx=%0d out=%0d,%0d,%0d want 1 0 0 0 1024,0,768",
                 k, ovl0, ir0, rd0, idx0, ov0[0], ov0[1], ov0[2]);
      else passed++;
    end
    iv0 = 1'b0;
    consume0;
    tick;
    total++;
    if (ir0 !== 1'b1 || rd0 !== 1'b0 || ovl0 !== 1'b0)
      $display("FAIL hold no_capture: in_ready=%b rd=%b out_valid=%b want 1 0 0", ir0, rd0, ovl0);
    else passed++;
  endtask

  task automatic test_reset_midrun;
    int lat;
    set_mem(0, 256, 0, -256, 0, 128, 256);
    iv0 = 1'b1; vin0 = {4{16'd256}};
    tick;
    iv0 = 1'b0;
    repeat (6) tick;
    total++;
    if (rd0 !== 1'b1 || ov0[0] !== 16'd1024)
      $display("FAIL midrun pre: rd=%b out0=%0d want 1 1024", rd0, ov0[0]);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (rd0 !== 1'b0 || ovl0 !== 1'b0 || ir0 !== 1'b1 || ov0 !== '0 || idx0 !== 2'd0)
      $display("FAIL midrun abort: rd=%b ov=%b ir=%b out=%h idx=%0d want 0 0 1 0 0", rd0, ovl0, ir0, ov0, idx0);
    else passed++;
    tick;
    rst = 1'b0;
    tick;
    run0({4{16'd256}}, lat);
    total++;
    if (lat !== 19 || ov0[0] !== 16'd1024 || ov0[1] !== 16'd0 || ov0[2] !== 16'd768 || idx0 !== 2'd0)
      $display("FAIL midrun rerun: lat=%0d out=%0d,%0d,%0d idx=%0d want 19 1024,0,768 0",
               lat, ov0[0], ov0[1], ov0[2], idx0);
    else passed++;
    consume0;
  endtask

  task automatic test_back_to_back;
    logic [3:0][15:0] vecs [3];
    int e [3][4];
    int tv [3];
    int k, outs, naddr;
    vecs[0] = {4{16'd256}};
    vecs[1] = {4{16'd512}};
    vecs[2] = '0;
    e[0] = '{1024, 0, 768, 0};
    e[1] = '{2048, 0, 1280, 0};
    e[2] = '{0, 0, 256, 2};
    set_mem(0, 256, 0, -256, 0, 128, 256);
    k = 0; outs = 0; naddr = 0;
    ordy0 = 1'b1; iv0 = 1'b0;
    for (int c = 0; c < 200 && outs < 3; c++) begin
      if (rd0) begin
        total++;
        if (addr0 !== 4'(naddr % 15)) $display("FAIL b2b addr #%0d: got %0d want %0d", naddr, addr0, naddr % 15);
        else passed++;
        naddr++;
      end
      if (ovl0) begin
        total++;
        if (ov0[0] !== 16'(e[outs][0]) || ov0[1] !== 16'(e[outs][1]) ||
            ov0[2] !== 16'(e[outs][2]) || idx0 !== 2'(e[outs][3]))
          $display("FAIL b2b result%0d: out=%0d,%0d,%0d idx=%0d want %0d,%0d,%0d idx=%0d", outs,
                   ov0[0], ov0[1], ov0[2], idx0, e[outs][0], e[outs][1], e[outs][2], e[outs][3]);
        else passed++;
        tv[outs] = c;
        outs++;
      end
      if (ir0) begin
        if (k < 3) begin iv0 = 1'b1; vin0 = vecs[k]; k++; end
        else iv0 = 1'b0;
      end
      tick;
    end
    iv0 = 1'b0; ordy0 = 1'b0;
    total++;
    if (outs !== 3) $display("FAIL b2b count: got %0d results want 3", outs);
    else passed++;
    if (outs == 3) begin
      total++;
      if (tv[0] !== 19 || tv[1] - tv[0] !== 20 || tv[2] - tv[1] !== 20)
        $display("FAIL b2b timing: out_valid at %0d,%0d,%0d want 19,39,59", tv[0], tv[1], tv[2]);
      else passed++;
    end
    total++;
    if (naddr !== 45) $display("FAIL b2b reads: got %0d want 45", naddr); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_argmax_tie;
    test_saturation;
    test_floor;
    test_backpressure;
    test_reset_midrun;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
